branch_global_dpath: RTL and testbench

Datapath half of the global (gshare) branch predictor. It holds the pattern history table (PHT) of 2-bit saturating counters and the global history register (GHR), and produces the combinational `prediction` for the fetch PC. It latches the branch being resolved on `update_en`, reports that entry's saturation status to `lab4_branch_BranchGlobalCtrl`, and applies the controller's `increment_entry`, `decrement_entry` and `update_ghr` commands one cycle later.

---
 rtl/branch_global_dpath.sv | 76 +++++++
 tb/tb_branch_global_dpath.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_global_dpath.sv
// Global branch predictor datapath: 2-bit counter PHT, global history and resolve latch.
// Build option LAB4_BRANCH_GSHARE_EN selects gshare (PC ^ ghr) indexing; otherwise GAg (ghr only).
module branch_global_dpath #(
    parameter int PHT_size = 2048,
    localparam int W = $clog2(PHT_size)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic        prediction,
    input  logic        update_en,
    input  logic        update_val,
    output logic        entry_upper_reached,
    output logic        entry_lower_reached,
    input  logic        increment_entry,
    input  logic        decrement_entry,
    input  logic        update_ghr
);

    logic [1:0]   pht [PHT_size];
    logic [W-1:0] ghr;
    logic [W-1:0] upd_idx;
    logic         upd_val;
    logic [W-1:0] cur_idx;
    logic [1:0]   upd_entry;
    logic         pc_unused;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

`ifdef LAB4_BRANCH_GSHARE_EN
    assign cur_idx = PC[W+1:2] ^ ghr;
`else
    assign cur_idx = ghr;
`endif
    // Only PC[W+1:2] feeds the index (and nothing at all in the GAg build).
    assign pc_unused = ^PC;

    assign prediction          = pht[cur_idx][1];
    assign upd_entry           = pht[upd_idx];
    assign entry_upper_reached = (upd_entry == 2'b11);
    assign entry_lower_reached = (upd_entry == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr     <= '0;
            upd_idx <= '0;
            upd_val <= 1'b0;
        end else begin
            if (update_en) begin
                upd_idx <= cur_idx;
                upd_val <= update_val;
            end
            if (update_ghr)
                ghr <= {ghr[W-2:0], upd_val};
        end
    end

    // Both commands at once cancel; saturation is enforced here regardless of ctrl gating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHT_size; i++)
                pht[i] <= 2'b01;
        end else if (increment_entry && !decrement_entry) begin
            pht[upd_idx] <= sat_inc(upd_entry);
        end else if (decrement_entry && !increment_entry) begin
            pht[upd_idx] <= sat_dec(upd_entry);
        end
    end

endmodule

// File: tb/tb_branch_global_dpath.sv
// Directed bench for branch_global_dpath; expectations follow LAB4_BRANCH_GSHARE_EN when defined.
module tb_branch_global_dpath;

`ifdef LAB4_BRANCH_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif
    localparam int I1 = GS ? 'h040 : 0;   // index latched for PC 0x100 with ghr 0
    localparam int I2 = GS ? 'h080 : 0;   // index latched for PC 0x200 with ghr 0

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PC = 32'h0;
    logic        prediction;
    logic        update_en = 1'b0;
    logic        update_val = 1'b0;
    logic        entry_upper_reached;
    logic        entry_lower_reached;
    logic        increment_entry = 1'b0;
    logic        decrement_entry = 1'b0;
    logic        update_ghr = 1'b0;

    int checks = 0;
    int errors = 0;

    branch_global_dpath #(.PHT_size(2048)) dut (
        .clk(clk),
        .reset(reset),
        .PC(PC),
        .prediction(prediction),
        .update_en(update_en),
        .update_val(update_val),
        .entry_upper_reached(entry_upper_reached),
        .entry_lower_reached(entry_lower_reached),
        .increment_entry(increment_entry),
        .decrement_entry(decrement_entry),
        .update_ghr(update_ghr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        update_en = 1'b0;
        update_val = 1'b0;
        increment_entry = 1'b0;
        decrement_entry = 1'b0;
        update_ghr = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic latch_branch(input logic [31:0] pc, input logic val);
        PC = pc;
        update_en = 1'b1;
        update_val = val;
        tick();
        update_en = 1'b0;
        update_val = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        PC = 32'h100;
        #1;
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL reset_pred_100 got %b want 0", prediction);
        end
        PC = 32'h7fc;
        #1;
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL reset_pred_7fc got %b want 0", prediction);
        end
        checks++;
        if (dut.ghr !== 11'h0) begin
            errors++; $display("FAIL reset_ghr got %h want 000", dut.ghr);
        end
        tick();
        reset = 1'b0;
        latch_branch(32'h100, 1'b0);
        @(negedge clk);
        checks++;
        if ({entry_upper_reached, entry_lower_reached} !== 2'b00) begin
            errors++; $display("FAIL reset_status got %b want 00", {entry_upper_reached, entry_lower_reached});
        end
    endtask

    task automatic test_taken_update();
        do_reset();
        latch_branch(32'h100, 1'b1);
        increment_entry = 1'b1;
        update_ghr = 1'b1;
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut.ghr !== 11'h001) begin
            errors++; $display("FAIL taken_ghr got %h want 001", dut.ghr);
        end
        checks++;
        if (dut.pht[I1] !== 2'b10) begin
            errors++; $display("FAIL taken_entry got %b want 10", dut.pht[I1]);
        end
        PC = 32'h104;
        #1;
        checks++;
        if (prediction !== GS) begin
            errors++; $display("FAIL taken_pred_104 got %b want %b", prediction, GS);
        end
        PC = 32'h100;
        #1;
        checks++;
        if (prediction !== 1'b0) begin
            errors++; $display("FAIL taken_pred_100 got %b want 0", prediction);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_up  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_lo  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_pd  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        latch_branch(32'h100, 1'b1);
        PC = 32'h100;
        increment_entry = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (entry_upper_reached !== exp_up[k][0] || entry_lower_reached !== 1'b0) begin
                errors++; $display("FAIL sat_inc%0d got up=%b lo=%b want up=%b lo=0", k + 1, entry_upper_reached, entry_lower_reached, exp_up[k][0]);
            end
        end
        checks++;
        if (dut.pht[I1] !== 2'b11 || prediction !== 1'b1) begin
            errors++; $display("FAIL sat_top got entry=%b pred=%b want entry=11 pred=1", dut.pht[I1], prediction);
        end
        increment_entry = 1'b0;
        decrement_entry = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (entry_lower_reached !== exp_lo[k][0] || entry_upper_reached !== 1'b0 || prediction !== exp_pd[k]) begin
                errors++; $display("FAIL sat_dec%0d got lo=%b up=%b pred=%b want lo=%b up=0 pred=%b", k + 1, entry_lower_reached, entry_upper_reached, prediction, exp_lo[k][0], exp_pd[k]);
            end
        end
        decrement_entry = 1'b0;
        checks++;
        if (dut.pht[I1] !== 2'b00) begin
            errors++; $display("FAIL sat_bottom got %b want 00", dut.pht[I1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        latch_branch(32'h100, 1'b1);
        PC = 32'h200;
        update_en = 1'b1;
        update_val = 1'b0;
        increment_entry = 1'b1;
        update_ghr = 1'b1;
        tick();
        update_en = 1'b0;
        increment_entry = 1'b0;
        decrement_entry = 1'b1;
        update_ghr = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.upd_idx !== 11'(I2) || dut.ghr !== 11'h001) begin
            errors++; $display("FAIL b2b_latch got idx=%h ghr=%h want idx=%h ghr=001", dut.upd_idx, dut.ghr, 11'(I2));
        end
        PC = 32'h104;
        #1;
        checks++;
        if (prediction !== GS) begin
            errors++; $display("FAIL b2b_first_cmd got pred=%b want %b", prediction, GS);
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut.ghr !== 11'h002) begin
            errors++; $display("FAIL b2b_ghr got %h want 002", dut.ghr);
        end
        checks++;
        if (entry_lower_reached !== GS || entry_upper_reached !== 1'b0) begin
            errors++; $display("FAIL b2b_status got lo=%b up=%b want lo=%b up=0", entry_lower_reached, entry_upper_reached, GS);
        end
        PC = 32'h108;
        #1;
        checks++;
        if (prediction !== GS) begin
            errors++; $display("FAIL b2b_pred_108 got %b want %b", prediction, GS);
        end
        checks++;
        if (dut.pht[I1] !== (GS ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL b2b_entry1 got %b want %b", dut.pht[I1], (GS ? 2'b10 : 2'b01));
        end
    endtask

    task automatic test_reset_mid_update();
        do_reset();
        latch_branch(32'h100, 1'b1);
        increment_entry = 1'b1;
        update_ghr = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (dut.ghr !== 11'h001 || dut.pht[I1] !== 2'b10) begin
            errors++; $display("FAIL mid_pre got ghr=%h entry=%b want ghr=001 entry=10", dut.ghr, dut.pht[I1]);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (dut.ghr !== 11'h000 || dut.pht[I1] !== 2'b01 || dut.upd_val !== 1'b0) begin
            errors++; $display("FAIL mid_async got ghr=%h entry=%b val=%b want ghr=000 entry=01 val=0", dut.ghr, dut.pht[I1], dut.upd_val);
        end
        tick();
        checks++;
        if (dut.ghr !== 11'h000 || dut.pht[I1] !== 2'b01) begin
            errors++; $display("FAIL mid_cmd_ignored got ghr=%h entry=%b want ghr=000 entry=01", dut.ghr, dut.pht[I1]);
        end
        reset = 1'b0;
        clear_inputs();
        latch_branch(32'h100, 1'b1);
        increment_entry = 1'b1;
        update_ghr = 1'b1;
        tick();
        clear_inputs();
        PC = 32'h104;
        @(negedge clk);
        checks++;
        if (dut.ghr !== 11'h001 || dut.pht[I1] !== 2'b10 || prediction !== GS) begin
            errors++; $display("FAIL mid_after got ghr=%h entry=%b pred=%b want ghr=001 entry=10 pred=%b", dut.ghr, dut.pht[I1], prediction, GS);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        latch_branch(32'h100, 1'b1);
        increment_entry = 1'b1;
        decrement_entry = 1'b1;
        update_ghr = 1'b1;
        tick();
        update_ghr = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.pht[I1] !== 2'b01 || dut.ghr !== 11'h001 || dut.upd_idx !== 11'(I1)) begin
            errors++; $display("FAIL conflict_ghr got entry=%b ghr=%h idx=%h want entry=01 ghr=001 idx=%h", dut.pht[I1], dut.ghr, dut.upd_idx, 11'(I1));
        end
        tick();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (dut.pht[I1] !== 2'b01 || dut.ghr !== 11'h001) begin
            errors++; $display("FAIL conflict_hold got entry=%b ghr=%h want entry=01 ghr=001", dut.pht[I1], dut.ghr);
        end
    endtask

    initial begin
        test_reset();
        test_taken_update();
        test_saturation();
        test_back_to_back();
        test_reset_mid_update();
        test_conflict();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
